// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the DataMemory port arbiter.
// Contents:
//   NUM_PORTS    number of requesters sharing DataMemory
//   port_idx_t   requester index (1 bit for two ports)
//   arb_state_e  transaction FSM states: idle, strobe issue, read-data wait
//   is_misaligned  helper for the optional word-alignment check
package dmem_arb_pkg;

    localparam int unsigned NUM_PORTS  = 2;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // A word access is misaligned when either byte-offset bit is set.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return (byte_off != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker.
// Ports:
//   valid0, valid1  request valids from port 0 / port 1
//   last_grant      port that won the previous arbitration
//   grant           selected port (meaningful only when any = 1)
//   any             at least one request is valid
// A lone valid always wins; on a tie the port that did not win last time wins.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic      valid0,
    input  logic      valid1,
    input  port_idx_t last_grant,
    output port_idx_t grant,
    output logic      any
);

    // Combinational winner selection.
    always_comb begin
        any   = valid0 | valid1;
        grant = 1'b0;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (valid1) begin
            grant = 1'b1;
        end else begin
            grant = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port DataMemory between port 0 (CPU load/store) and
// port 1 (auxiliary/DMA/debug loader). Round-robin grant, one transaction in
// flight, every output registered.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   req<p>_valid/_write/_addr/_wdata   request from port p (held until ready)
//   req<p>_ready              one-cycle accept pulse
//   rsp<p>_valid/_rdata/_err  one-cycle response with load data / echoed store data
//   mem_addr/_wdata/_read/_write       DataMemory command
//   mem_rdata                 DataMemory registered read data
// Build option: DMEM_ARB_ALIGN_CHECK_EN enables the word-alignment check; a
// misaligned winner is accepted but never reaches memory and gets rsp_err=1.
// Timing: accept at edge E0 (strobe raised), memory acts at E1 (strobe dropped),
// read data captured at E2 with the response pulse; idle again from E2.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_r, state_s;
    port_idx_t         last_grant_r, last_grant_s;
    port_idx_t         port_r, port_s;
    logic              misalign_r, misalign_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic              mem_read_r, mem_read_s;
    logic              mem_write_r, mem_write_s;
    logic              ready0_r, ready0_s, ready1_r, ready1_s;
    logic              rsp0_valid_r, rsp0_valid_s, rsp1_valid_r, rsp1_valid_s;
    logic [DATA_W-1:0] rsp0_rdata_r, rsp0_rdata_s, rsp1_rdata_r, rsp1_rdata_s;
    logic              rsp0_err_r, rsp0_err_s, rsp1_err_r, rsp1_err_s;

    port_idx_t         grant_s;
    logic              any_s;
    logic              sel_write_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              bad_align_s;
    logic [DATA_W-1:0] rsp_data_s;

    dmem_rr_pick u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .any        (any_s)
    );

    // Route the winning port's request fields.
    always_comb begin
        sel_write_s = req0_write;
        sel_addr_s  = req0_addr;
        sel_wdata_s = req0_wdata;
        if (grant_s == 1'b1) begin
            sel_write_s = req1_write;
            sel_addr_s  = req1_addr;
            sel_wdata_s = req1_wdata;
        end else begin
            sel_write_s = req0_write;
            sel_addr_s  = req0_addr;
            sel_wdata_s = req0_wdata;
        end
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign bad_align_s = is_misaligned(sel_addr_s[1:0]);
`else
    assign bad_align_s = 1'b0;
`endif

    // A rejected (misaligned) access never touched memory, so it returns zero.
    assign rsp_data_s = misalign_r ? {DATA_W{1'b0}} : mem_rdata;

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        port_s       = port_r;
        misalign_s   = misalign_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ready0_s     = 1'b0;
        ready1_s     = 1'b0;
        rsp0_valid_s = 1'b0;
        rsp1_valid_s = 1'b0;
        rsp0_rdata_s = rsp0_rdata_r;
        rsp1_rdata_s = rsp1_rdata_r;
        rsp0_err_s   = 1'b0;
        rsp1_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_s      = ST_ISSUE;
                    last_grant_s = grant_s;
                    port_s       = grant_s;
                    misalign_s   = bad_align_s;
                    mem_addr_s   = sel_addr_s;
                    mem_wdata_s  = sel_wdata_s;
                    if (grant_s == 1'b1) begin
                        ready1_s = 1'b1;
                    end else begin
                        ready0_s = 1'b1;
                    end
                    // Misaligned winners still walk ISSUE/WAIT, just without a strobe.
                    if (!bad_align_s) begin
                        mem_read_s  = ~sel_write_s;
                        mem_write_s = sel_write_s;
                    end else begin
                        mem_read_s  = 1'b0;
                        mem_write_s = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                state_s = ST_IDLE;
                if (port_r == 1'b1) begin
                    rsp1_valid_s = 1'b1;
                    rsp1_rdata_s = rsp_data_s;
                    rsp1_err_s   = misalign_r;
                end else begin
                    rsp0_valid_s = 1'b1;
                    rsp0_rdata_s = rsp_data_s;
                    rsp0_err_s   = misalign_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; async reset also drops strobes mid-transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            port_r       <= 1'b0;
            misalign_r   <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            ready0_r     <= 1'b0;
            ready1_r     <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp0_rdata_r <= {DATA_W{1'b0}};
            rsp1_rdata_r <= {DATA_W{1'b0}};
            rsp0_err_r   <= 1'b0;
            rsp1_err_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
            port_r       <= port_s;
            misalign_r   <= misalign_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            mem_read_r   <= mem_read_s;
            mem_write_r  <= mem_write_s;
            ready0_r     <= ready0_s;
            ready1_r     <= ready1_s;
            rsp0_valid_r <= rsp0_valid_s;
            rsp1_valid_r <= rsp1_valid_s;
            rsp0_rdata_r <= rsp0_rdata_s;
            rsp1_rdata_r <= rsp1_rdata_s;
            rsp0_err_r   <= rsp0_err_s;
            rsp1_err_r   <= rsp1_err_s;
        end
    end

    assign req0_ready = ready0_r;
    assign req1_ready = ready1_r;
    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp0_rdata = rsp0_rdata_r;
    assign rsp1_rdata = rsp1_rdata_r;
    assign rsp0_err   = rsp0_err_r;
    assign rsp1_err   = rsp1_err_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_read   = mem_read_r;
    assign mem_write  = mem_write_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a small registered
// DataMemory model (16 words, read data one cycle after the strobe edge,
// stores echo WriteData on ReadData).
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic        req0_ready, rsp0_valid, rsp0_err, req1_ready, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [31:0] mem [0:15] = '{32'hA0A0_0000, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0000_0000,
                                32'hA5A5_0004, 32'h0000_0005, 32'h0000_0006, 32'h0000_0007,
                                32'h0000_0008, 32'h0000_0009, 32'h0000_000A, 32'h0000_000B,
                                32'h0000_000C, 32'h0000_000D, 32'h0000_000E, 32'h0000_000F};
    logic [31:0] mem_rdata_q = 32'h0;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_ready0 = 0, cnt_ready1 = 0, cnt_rsp0 = 0, cnt_rsp1 = 0, cnt_mwr = 0;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMemory model: registered read, stores echo the written word.
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[5:2]] <= mem_wdata;
            mem_rdata_q        <= mem_wdata;
        end else if (mem_read) begin
            mem_rdata_q <= mem[mem_addr[5:2]];
        end
    end
    assign mem_rdata = mem_rdata_q;

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (req0_ready) cnt_ready0 <= cnt_ready0 + 1;
        if (req1_ready) cnt_ready1 <= cnt_ready1 + 1;
        if (rsp0_valid) cnt_rsp0 <= cnt_rsp0 + 1;
        if (rsp1_valid) cnt_rsp1 <= cnt_rsp1 + 1;
        if (mem_write)  cnt_mwr <= cnt_mwr + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and collect its response (bounded waits, no checking).
    task automatic do_txn(input bit port, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output bit acc, output bit rsp,
                          output logic [31:0] rdata, output bit err, output int lat);
        acc = 1'b0; rsp = 1'b0; rdata = 32'h0; err = 1'b0; lat = 0;
        if (port) begin
            req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_wdata = wdata;
        end else begin
            req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_wdata = wdata;
        end
        for (int i = 0; i < 20 && !acc; i++) begin
            tick();
            if (port ? req1_ready : req0_ready) acc = 1'b1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 10 && acc && !rsp; i++) begin
            tick();
            lat++;
            if (port ? rsp1_valid : rsp0_valid) begin
                rsp = 1'b1;
                rdata = port ? rsp1_rdata : rsp0_rdata;
                err = port ? rsp1_err : rsp0_err;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready); end
        n_checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b%b expected 00", rsp0_valid, rsp1_valid); end
        n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_errors++; $display("FAIL reset_strobes: got %b%b expected 00", mem_read, mem_write); end
        n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_errors++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wdata); end
        n_checks++; if (rsp0_rdata !== 32'h0 || rsp1_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", rsp0_rdata, rsp1_rdata); end
        n_checks++; if (rsp0_err !== 1'b0 || rsp1_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b%b expected 00", rsp0_err, rsp1_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_port0();
        int r1_0, s1_0;
        r1_0 = cnt_ready1; s1_0 = cnt_rsp1;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h08;
        tick();  // E0
        n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL ld0_ready_e0: got %b expected 1", req0_ready); end
        n_checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h08) begin n_errors++; $display("FAIL ld0_strobe: got rd=%b wr=%b addr=%h expected 1 0 00000008", mem_read, mem_write, mem_addr); end
        req0_valid = 1'b0;
        tick();  // E1
        n_checks++; if (req0_ready !== 1'b0 || mem_read !== 1'b0 || rsp0_valid !== 1'b0) begin n_errors++; $display("FAIL ld0_e1: got rdy=%b rd=%b rsp=%b expected 000", req0_ready, mem_read, rsp0_valid); end
        tick();  // E2
        n_checks++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEAD_BEEF || rsp0_err !== 1'b0) begin n_errors++; $display("FAIL ld0_rsp: got v=%b d=%h e=%b expected 1 deadbeef 0", rsp0_valid, rsp0_rdata, rsp0_err); end
        tick();
        n_checks++; if (rsp0_valid !== 1'b0) begin n_errors++; $display("FAIL ld0_rsp_pulse: got %b expected 0", rsp0_valid); end
        n_checks++; if (cnt_ready1 != r1_0 || cnt_rsp1 != s1_0) begin n_errors++; $display("FAIL ld0_port1_quiet: got %0d/%0d pulses expected 0/0", cnt_ready1 - r1_0, cnt_rsp1 - s1_0); end
    endtask

    task automatic test_store_load_port1();
        bit acc, rsp, err; logic [31:0] d; int lat; int w0, s0;
        w0 = cnt_mwr; s0 = cnt_rsp0;
        do_txn(1'b1, 1'b1, 32'h0C, 32'h0000_1234, acc, rsp, d, err, lat);
        n_checks++; if (!acc || !rsp) begin n_errors++; $display("FAIL st1_handshake: got acc=%b rsp=%b expected 1 1", acc, rsp); end
        n_checks++; if (d !== 32'h0000_1234 || err !== 1'b0) begin n_errors++; $display("FAIL st1_echo: got %h err=%b expected 00001234 0", d, err); end
        n_checks++; if (lat != 2) begin n_errors++; $display("FAIL st1_latency: got %0d expected 2", lat); end
        n_checks++; if (cnt_mwr - w0 != 1 || mem[3] !== 32'h0000_1234) begin n_errors++; $display("FAIL st1_mem: got writes=%0d word=%h expected 1 00001234", cnt_mwr - w0, mem[3]); end
        do_txn(1'b1, 1'b0, 32'h0C, 32'h0, acc, rsp, d, err, lat);
        n_checks++; if (!rsp || d !== 32'h0000_1234) begin n_errors++; $display("FAIL ld1_readback: got rsp=%b d=%h expected 1 00001234", rsp, d); end
        n_checks++; if (cnt_rsp0 != s0) begin n_errors++; $display("FAIL st1_port0_quiet: got %0d expected 0", cnt_rsp0 - s0); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] r0, r1, v0, v1;
        r0 = 12'h0; r1 = 12'h0; v0 = 12'h0; v1 = 12'h0;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h00;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h04;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            r0[i] = req0_ready; r1[i] = req1_ready; v0[i] = rsp0_valid; v1[i] = rsp1_valid;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++; if (r0 !== 12'h041) begin n_errors++; $display("FAIL b2b_ready0: got %h expected 041", r0); end
        n_checks++; if (r1 !== 12'h208) begin n_errors++; $display("FAIL b2b_ready1: got %h expected 208", r1); end
        n_checks++; if (v0 !== 12'h104) begin n_errors++; $display("FAIL b2b_rsp0: got %h expected 104", v0); end
        n_checks++; if (v1 !== 12'h820) begin n_errors++; $display("FAIL b2b_rsp1: got %h expected 820", v1); end
        n_checks++; if (rsp0_rdata !== 32'hA0A0_0000 || rsp1_rdata !== 32'h1111_1111) begin n_errors++; $display("FAIL b2b_data: got %h/%h expected a0a00000/11111111", rsp0_rdata, rsp1_rdata); end
        tick(); tick(); tick();
    endtask

    task automatic test_busy_hold();
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h04;
        tick();  // E0: port 1 accepted
        n_checks++; if (req1_ready !== 1'b1) begin n_errors++; $display("FAIL busy_ready1: got %b expected 1", req1_ready); end
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h08;
        tick();  // E1 in ISSUE
        n_checks++; if (req0_ready !== 1'b0) begin n_errors++; $display("FAIL busy_ready0_issue: got %b expected 0", req0_ready); end
        tick();  // E2 in WAIT
        n_checks++; if (req0_ready !== 1'b0 || rsp1_valid !== 1'b1) begin n_errors++; $display("FAIL busy_wait: got rdy0=%b rsp1=%b expected 0 1", req0_ready, rsp1_valid); end
        tick();  // back in IDLE: port 0 accepted
        n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL busy_ready0_idle: got %b expected 1", req0_ready); end
        req0_valid = 1'b0;
        tick(); tick();
        n_checks++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL busy_rsp0: got v=%b d=%h expected 1 deadbeef", rsp0_valid, rsp0_rdata); end
        tick();
    endtask

    task automatic test_reset_abort();
        bit acc, rsp, err; logic [31:0] d; int lat; int s0, w0;
        s0 = cnt_rsp0; w0 = cnt_mwr;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h10; req0_wdata = 32'hFFFF_FFFF;
        tick();  // E0: store strobe up
        n_checks++; if (mem_write !== 1'b1) begin n_errors++; $display("FAIL abort_strobe_up: got %b expected 1", mem_write); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || req0_ready !== 1'b0) begin n_errors++; $display("FAIL abort_async_clear: got wr=%b rd=%b rdy=%b expected 000", mem_write, mem_read, req0_ready); end
        req0_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        n_checks++; if (cnt_rsp0 != s0 || cnt_mwr != w0) begin n_errors++; $display("FAIL abort_no_rsp: got rsp=%0d wr=%0d expected 0 0", cnt_rsp0 - s0, cnt_mwr - w0); end
        n_checks++; if (mem[4] !== 32'hA5A5_0004) begin n_errors++; $display("FAIL abort_mem_kept: got %h expected a5a50004", mem[4]); end
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, acc, rsp, d, err, lat);
        n_checks++; if (!rsp || d !== 32'hA5A5_0004) begin n_errors++; $display("FAIL abort_readback: got rsp=%b d=%h expected 1 a5a50004", rsp, d); end
    endtask

    task automatic test_misaligned();
        bit acc, rsp, err; logic [31:0] d; int lat; int w0;
        w0 = cnt_mwr;
        do_txn(1'b0, 1'b1, 32'h06, 32'h5555_AAAA, acc, rsp, d, err, lat);
        n_checks++; if (!acc || !rsp || lat != 2) begin n_errors++; $display("FAIL mis_handshake: got acc=%b rsp=%b lat=%0d expected 1 1 2", acc, rsp, lat); end
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        n_checks++; if (err !== 1'b1 || d !== 32'h0) begin n_errors++; $display("FAIL mis_err: got err=%b d=%h expected 1 00000000", err, d); end
        n_checks++; if (cnt_mwr != w0) begin n_errors++; $display("FAIL mis_no_write: got %0d writes expected 0", cnt_mwr - w0); end
`else
        n_checks++; if (err !== 1'b0 || d !== 32'h5555_AAAA) begin n_errors++; $display("FAIL mis_err: got err=%b d=%h expected 0 5555aaaa", err, d); end
        n_checks++; if (cnt_mwr - w0 != 1) begin n_errors++; $display("FAIL mis_write: got %0d writes expected 1", cnt_mwr - w0); end
`endif
    endtask

    initial begin
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 32'h0; req0_wdata = 32'h0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 32'h0; req1_wdata = 32'h0;
        test_reset();
        test_load_port0();
        test_store_load_port1();
        test_back_to_back();
        test_busy_hold();
        test_reset_abort();
        test_misaligned();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
